// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: SPI mode-0 flash controller issuing command, optional address and read/write data phases
module spi_flash_ctrl #(
   parameter int ADDR_W    = 24,
   parameter int MAX_BYTES = 4,
   parameter int CLK_DIV   = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [7:0]                     cmd,
   input  logic                           has_addr,
   input  logic [ADDR_W-1:0]              addr,
   input  logic                           rw,
   input  logic [$clog2(MAX_BYTES+1)-1:0] nbytes,
   input  logic [8*MAX_BYTES-1:0]         wdata,
   output logic                           busy,
   output logic                           done,
   output logic [8*MAX_BYTES-1:0]         rdata,
   output logic                           cs_n,
   output logic                           sclk,
   output logic                           mosi,
   input  logic                           miso
);
   localparam int NBW  = $clog2(MAX_BYTES+1);
   localparam int DW   = $clog2(2*CLK_DIV+1);
   localparam int SR_W = 8 + ADDR_W + 8*MAX_BYTES;
   localparam int BITW = $clog2(SR_W+1);
   localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV-1);
   localparam logic [DW-1:0] GAP_END = DW'(2*CLK_DIV-1);

   typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, ADDR, DATA, CS_HOLD, CS_GAP, DONE} state_t;

   state_t                r_state, w_nxt, w_after_addr;
   logic [DW-1:0]         r_div;
   logic                  r_ph;
   logic [BITW-1:0]       r_bit;
   logic [SR_W-1:0]       r_sr;
   logic                  r_has_addr;
   logic                  r_rw;
   logic [NBW-1:0]        r_nb;
   logic [8*MAX_BYTES-1:0] r_rdata;

   logic                  w_acc, w_tick, w_bitst, w_bit_end, w_last, w_samp;
   logic [NBW-1:0]        w_nb;
   logic [BITW-1:0]       w_plast;
   logic [8*MAX_BYTES-1:0] w_wd_al;
   logic [SR_W-1:0]       w_load;

   assign w_acc     = start && (r_state == IDLE || r_state == DONE);
   assign w_tick    = r_div == DIV_END;
   assign w_bitst   = r_state inside {CMD, ADDR, DATA};
   assign w_bit_end = w_bitst && r_ph && w_tick;
   assign w_plast   = r_state == CMD  ? BITW'(7) :
                      r_state == ADDR ? BITW'(ADDR_W-1) : BITW'(8*r_nb-1);
   assign w_last    = r_bit == w_plast;
   // miso is captured at the end of the first cycle of each high half
   assign w_samp    = r_state == DATA && r_rw && r_ph && r_div == '0;
   assign w_nb      = nbytes > NBW'(MAX_BYTES) ? NBW'(MAX_BYTES) : nbytes;
   assign w_wd_al   = wdata << (8*(MAX_BYTES - int'(w_nb)));
   assign w_load    = has_addr ? {cmd, addr, w_wd_al} : {cmd, w_wd_al, {ADDR_W{1'b0}}};
   assign w_after_addr = r_nb != '0 ? DATA : CS_HOLD;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:     w_nxt = w_acc ? CS_SETUP : IDLE;
         CS_SETUP: w_nxt = w_tick ? CMD : CS_SETUP;
         CMD:      w_nxt = (w_bit_end && w_last) ? (r_has_addr ? ADDR : w_after_addr) : CMD;
         ADDR:     w_nxt = (w_bit_end && w_last) ? w_after_addr : ADDR;
         DATA:     w_nxt = (w_bit_end && w_last) ? CS_HOLD : DATA;
         CS_HOLD:  w_nxt = w_tick ? CS_GAP : CS_HOLD;
         CS_GAP:   w_nxt = r_div == GAP_END ? DONE : CS_GAP;
         DONE:     w_nxt = w_acc ? CS_SETUP : IDLE;
         default:  w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_div      <= '0;
         r_ph       <= 1'b0;
         r_bit      <= '0;
         r_sr       <= '0;
         r_has_addr <= 1'b0;
         r_rw       <= 1'b0;
         r_nb       <= '0;
         r_rdata    <= '0;
      end else begin
         r_state <= w_nxt;
         r_div   <= (r_state == IDLE || w_nxt != r_state || (w_bitst && w_tick)) ? '0 : r_div + DW'(1);
         r_ph    <= w_bitst && (r_ph ^ w_tick);
         if (w_acc) begin
            r_sr       <= w_load;
            r_has_addr <= has_addr;
            r_rw       <= rw;
            r_nb       <= w_nb;
            if (rw) r_rdata <= '0;
         end else if (w_bit_end) begin
            r_sr  <= r_sr << 1;
            r_bit <= w_last ? '0 : r_bit + BITW'(1);
         end
         if (w_samp) r_rdata <= {r_rdata[8*MAX_BYTES-2:0], miso};
      end
   end

   assign busy  = r_state inside {CS_SETUP, CMD, ADDR, DATA, CS_HOLD, CS_GAP};
   assign done  = r_state == DONE;
   assign cs_n  = !(r_state inside {CS_SETUP, CMD, ADDR, DATA, CS_HOLD});
   assign sclk  = w_bitst && r_ph;
   assign mosi  = w_bitst && !(r_state == DATA && r_rw) && r_sr[SR_W-1];
   assign rdata = r_rdata;
endmodule

// File: tb/tb_spi_flash_ctrl.sv
// tb_spi_flash_ctrl: directed checks of wire order, timing, reads, reset abort and back-to-back starts
module tb_spi_flash_ctrl;
   logic        clk = 0;
   logic        rst = 1;
   logic        start = 0;
   logic [7:0]  cmd = 0;
   logic        has_addr = 0;
   logic [23:0] addr = 0;
   logic        rw = 0;
   logic [2:0]  nbytes = 0;
   logic [31:0] wdata = 0;
   logic        busy, done, cs_n, sclk, mosi;
   logic        miso = 0;
   logic [31:0] rdata;

   int          n_cmp = 0, n_err = 0;
   logic        clr = 0, rd_chk = 0, prev_sclk = 0;
   logic [63:0] stream = 0, mosi_sr = 0;
   int          busy_cnt, csl_cnt, done_cnt, n_rise, mosi_bad, hi_run, min_gap;
   bit          seen_low;

   spi_flash_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .cmd(cmd), .has_addr(has_addr), .addr(addr),
      .rw(rw), .nbytes(nbytes), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
      .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // slave model: presents the next stream bit as soon as each sclk rise is seen
   always @(negedge clk) begin
      if (clr) begin
         busy_cnt = 0; csl_cnt = 0; done_cnt = 0; n_rise = 0; mosi_sr = 0;
         mosi_bad = 0; hi_run = 0; seen_low = 0; min_gap = 999;
      end else begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (!cs_n) begin
            csl_cnt++;
            if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
            hi_run = 0;
            seen_low = 1;
         end else hi_run++;
         if (sclk && !prev_sclk) begin
            n_rise++;
            mosi_sr = {mosi_sr[62:0], mosi};
            if (n_rise <= 64) miso = stream[64-n_rise];
         end
         if (rd_chk && !cs_n && (n_rise > 32 || (n_rise == 32 && !sclk)) && mosi) mosi_bad++;
      end
      prev_sclk = sclk;
   end

   task automatic clear_mon();
      clr = 1;
      @(negedge clk);
      #1 clr = 0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      chk({tag, "_done_seen"}, 64'(seen), 1);
      @(negedge clk);
      #1;
   endtask

   task automatic run(input string tag, input logic [7:0] c, input logic ha, input logic [23:0] a,
                      input logic r, input logic [2:0] nb, input logic [31:0] wd, input logic [63:0] st);
      stream = st;
      rd_chk = r;
      clear_mon();
      cmd = c; has_addr = ha; addr = a; rw = r; nbytes = nb; wdata = wd;
      start = 1;
      @(negedge clk);
      start = 0;
      chk({tag, "_busy_rise"}, 64'(busy), 1);
      wait_done(tag);
   endtask

   initial begin
      start = 1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_cs_n", 64'(cs_n), 1);
      chk("rst_sclk", 64'(sclk), 0);
      chk("rst_mosi", 64'(mosi), 0);
      chk("rst_rdata", 64'(rdata), 0);
      start = 0;
      rst = 0;
      @(negedge clk);

      run("wr", 8'h56, 1, 24'h258AFA, 0, 3'd4, 32'h1234AADD, 64'h0);
      chk("wr_mosi", mosi_sr, 64'h56258AFA1234AADD);
      chk("wr_rises", 64'(n_rise), 64);
      chk("wr_busy", 64'(busy_cnt), 264);
      chk("wr_csl", 64'(csl_cnt), 260);
      chk("wr_done", 64'(done_cnt), 1);
      chk("wr_rdata", 64'(rdata), 0);

      run("rd", 8'hFF, 1, 24'h456FAB, 1, 3'd4, 32'h0, 64'h00000000A53C0FF0);
      chk("rd_rdata", 64'(rdata), 64'hA53C0FF0);
      chk("rd_mosi", mosi_sr, 64'hFF456FAB00000000);
      chk("rd_mosi_zero", 64'(mosi_bad), 0);

      run("co", 8'h06, 0, 24'h0, 0, 3'd0, 32'h0, 64'h0);
      chk("co_rises", 64'(n_rise), 8);
      chk("co_csl", 64'(csl_cnt), 36);
      chk("co_busy", 64'(busy_cnt), 40);
      chk("co_mosi", mosi_sr, 64'h06);

      run("rdf", 8'h03, 1, 24'h0, 1, 3'd4, 32'h0, 64'h00000000FFFFFFFF);
      chk("rdf_rdata", 64'(rdata), 64'hFFFFFFFF);
      run("prd", 8'h03, 1, 24'h123456, 1, 3'd2, 32'h0, 64'h0000000012340000);
      chk("prd_rdata", 64'(rdata), 64'h00001234);
      chk("prd_busy", 64'(busy_cnt), 200);
      chk("prd_mosi", mosi_sr, 64'h031234560000);

      run("sat", 8'h02, 1, 24'h000100, 0, 3'd7, 32'h11223344, 64'h0);
      chk("sat_mosi", mosi_sr, 64'h0200010011223344);
      chk("sat_busy", 64'(busy_cnt), 264);
      chk("sat_rdata", 64'(rdata), 64'h00001234);

      rd_chk = 0;
      clear_mon();
      cmd = 8'h06; has_addr = 0; nbytes = 0; rw = 0;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (3) begin
         @(negedge clk);
         start = 1; cmd = 8'hAB; has_addr = 1; nbytes = 3'd4;
         @(negedge clk);
         start = 0;
      end
      wait_done("tog");
      chk("tog_mosi", mosi_sr, 64'h06);
      chk("tog_busy", 64'(busy_cnt), 40);
      chk("tog_done", 64'(done_cnt), 1);

      clear_mon();
      cmd = 8'h06; has_addr = 0; nbytes = 0; rw = 0;
      start = 1;
      for (int i = 0; i < 1000 && start; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt == 3) start = 0;
      end
      start = 0;
      repeat (5) @(negedge clk);
      #1;
      chk("b2b_done", 64'(done_cnt), 3);
      chk("b2b_gap", 64'(min_gap), 5);
      chk("b2b_busy", 64'(busy_cnt), 120);

      stream = 0;
      clear_mon();
      cmd = 8'h56; has_addr = 1; addr = 24'h258AFA; rw = 0; nbytes = 3'd4; wdata = 32'h1234AADD;
      start = 1;
      @(negedge clk);
      start = 0;
      for (int i = 0; i < 1000 && n_rise < 20; i++) begin
         @(negedge clk);
         #1;
      end
      chk("abt_rises", 64'(n_rise), 20);
      rst = 1;
      @(negedge clk);
      chk("abt_cs_n", 64'(cs_n), 1);
      chk("abt_sclk", 64'(sclk), 0);
      chk("abt_busy", 64'(busy), 0);
      chk("abt_rdata", 64'(rdata), 0);
      rst = 0;
      repeat (300) @(negedge clk);
      #1;
      chk("abt_no_done", 64'(done_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
